// File: rtl/winner_seq_ctrl.sv
// Connect4 winner-screen sequencer: latch colour, slide text to centre, blink, hold, clear.
// Optional hold timeout back to CLEAR is enabled by defining WINNER_AUTO_RESTART_EN.
module winner_seq_ctrl #(
    parameter logic [9:0] START_X      = 10'd0,
    parameter logic [9:0] CENTER_X     = 10'd320,
    parameter int         STEP         = 8,
    parameter int         BLINK_FRAMES = 15,
    parameter int         BLINKS       = 3,
    parameter int         HOLD_FRAMES  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       win_valid,
    input  logic       win_player,
    input  logic       restart,
    output logic       screen_en,
    output logic       color,
    output logic [9:0] cursorX,
    output logic       busy,
    output logic       done
);

    // One frame counter serves both the blink half-period and the hold timeout.
    localparam int FC_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int FC_W   = $clog2(FC_MAX + 1);
    localparam int TG_W   = $clog2(2 * BLINKS + 1);

    localparam logic [FC_W-1:0] BLINK_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [TG_W-1:0] TOGGLE_LAST = TG_W'(2 * BLINKS - 1);
    localparam logic [10:0]     STEP_11     = 11'(STEP);
    localparam logic [10:0]     CENTER_11   = {1'b0, CENTER_X};
`ifdef WINNER_AUTO_RESTART_EN
    localparam logic [FC_W-1:0] HOLD_LAST   = FC_W'(HOLD_FRAMES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SLIDE = 3'd1,
        ST_BLINK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            screen_en_q, screen_en_d;
    logic            color_q, color_d;
    logic [9:0]      cursor_x_q, cursor_x_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [TG_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [10:0]     slide_sum;

    // Widened by one bit so the centre compare never wraps.
    assign slide_sum = {1'b0, cursor_x_q} + STEP_11;

    always_comb begin
        state_d      = state_q;
        screen_en_d  = screen_en_q;
        color_d      = color_q;
        cursor_x_d   = cursor_x_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        toggle_cnt_d = toggle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d      = ST_SLIDE;
                    color_d      = win_player;
                    cursor_x_d   = START_X;
                    screen_en_d  = 1'b1;
                    busy_d       = 1'b1;
                    frame_cnt_d  = '0;
                    toggle_cnt_d = '0;
                end
            end

            ST_SLIDE, ST_BLINK, ST_HOLD: begin
                if (restart) begin
                    state_d      = ST_CLEAR;
                    screen_en_d  = 1'b0;
                    frame_cnt_d  = '0;
                    toggle_cnt_d = '0;
                end else if (frame_tick) begin
                    case (state_q)
                        ST_SLIDE: begin
                            if (slide_sum >= CENTER_11) begin
                                cursor_x_d   = CENTER_X;
                                state_d      = ST_BLINK;
                                frame_cnt_d  = '0;
                                toggle_cnt_d = '0;
                            end else begin
                                cursor_x_d = slide_sum[9:0];
                            end
                        end

                        ST_BLINK: begin
                            if (frame_cnt_q == BLINK_LAST) begin
                                screen_en_d = ~screen_en_q;
                                frame_cnt_d = '0;
                                if (toggle_cnt_q == TOGGLE_LAST) begin
                                    state_d      = ST_HOLD;
                                    toggle_cnt_d = '0;
                                end else begin
                                    toggle_cnt_d = toggle_cnt_q + TG_W'(1);
                                end
                            end else begin
                                frame_cnt_d = frame_cnt_q + FC_W'(1);
                            end
                        end

                        ST_HOLD: begin
`ifdef WINNER_AUTO_RESTART_EN
                            if (frame_cnt_q == HOLD_LAST) begin
                                state_d     = ST_CLEAR;
                                screen_en_d = 1'b0;
                                frame_cnt_d = '0;
                            end else begin
                                frame_cnt_d = frame_cnt_q + FC_W'(1);
                            end
`else
                            frame_cnt_d = '0;
`endif
                        end

                        default: ;
                    endcase
                end
            end

            ST_CLEAR: begin
                screen_en_d = 1'b0;
                if (frame_tick) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    cursor_x_d = START_X;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                screen_en_d = 1'b0;
                busy_d      = 1'b0;
                cursor_x_d  = START_X;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            screen_en_q  <= 1'b0;
            color_q      <= 1'b0;
            cursor_x_q   <= START_X;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_cnt_q  <= '0;
            toggle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            screen_en_q  <= screen_en_d;
            color_q      <= color_d;
            cursor_x_q   <= cursor_x_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            frame_cnt_q  <= frame_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign screen_en = screen_en_q;
    assign color     = color_q;
    assign cursorX   = cursor_x_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_winner_seq_ctrl.sv
// Directed bench for winner_seq_ctrl: default instance plus a STEP=7 instance for the non-dividing slide.
module tb_winner_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       win_valid = 1'b0;
    logic       win_player = 1'b0;
    logic       restart = 1'b0;

    logic       screen_en, color, busy, done;
    logic [9:0] cursor_x;
    logic       s7_screen_en, s7_color, s7_busy, s7_done;
    logic [9:0] s7_cursor_x;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    winner_seq_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .win_valid(win_valid),
        .win_player(win_player), .restart(restart), .screen_en(screen_en),
        .color(color), .cursorX(cursor_x), .busy(busy), .done(done)
    );

    winner_seq_ctrl #(.STEP(7)) dut7 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .win_valid(win_valid),
        .win_player(win_player), .restart(restart), .screen_en(s7_screen_en),
        .color(s7_color), .cursorX(s7_cursor_x), .busy(s7_busy), .done(s7_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: a single-cycle tick followed by one quiet cycle.
    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    initial begin
        int exp8, exp7, bt;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_en", screen_en, 0);
        chk("rst_color", color, 0);
        chk("rst_cursor", cursor_x, 0);
        chk("rst_done", done, 0);

        // Red win starts the slide
        win_valid = 1'b1;
        win_player = 1'b1;
        step();
        win_valid = 1'b0;
        win_player = 1'b0;
        chk("win_busy", busy, 1);
        chk("win_en", screen_en, 1);
        chk("win_color", color, 1);
        chk("win_cursor", cursor_x, 0);
        chk("win7_cursor", s7_cursor_x, 0);

        // Slide: step 8 reaches 320 on tick 40, step 7 on tick 46
        for (int i = 1; i <= 46; i++) begin
            frame();
            exp8 = (8 * i > 320) ? 320 : 8 * i;
            exp7 = (7 * i > 320) ? 320 : 7 * i;
            chk($sformatf("slide8_t%0d", i), cursor_x, exp8);
            chk($sformatf("slide7_t%0d", i), s7_cursor_x, exp7);
            chk($sformatf("slide_en_t%0d", i), screen_en, 1);
        end
        chk("slide7_t45_bound", (s7_cursor_x <= 10'd320), 1);

        // Blink: the default instance has already seen 6 blink ticks
        for (bt = 7; bt <= 105; bt++) begin
            frame();
            if (bt <= 90)
                chk($sformatf("blink_en_t%0d", bt), screen_en, ((bt / 15) % 2 == 0) ? 1 : 0);
            else
                chk($sformatf("hold_en_t%0d", bt - 90), screen_en, 1);
            chk($sformatf("blink_cursor_t%0d", bt), cursor_x, 320);
        end
        chk("hold_busy", busy, 1);

        // Win pulse during HOLD must not re-latch colour
        win_valid = 1'b1;
        win_player = 1'b0;
        step();
        win_valid = 1'b0;
        chk("hold_rewin_color", color, 1);
        chk("hold_rewin_busy", busy, 1);
        chk("hold_rewin_cursor", cursor_x, 320);

`ifdef WINNER_AUTO_RESTART_EN
        // 15 HOLD ticks so far; timeout lands on the 300th
        for (int i = 16; i <= 299; i++) frame();
        chk("auto_pre_en", screen_en, 1);
        chk("auto_pre_busy", busy, 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("auto_clear_en", screen_en, 0);
        chk("auto_clear_busy", busy, 1);
        chk("auto_clear_done", done, 0);
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("auto_done", done, 1);
        chk("auto_done_busy", busy, 0);
        chk("auto_done_cursor", cursor_x, 0);
        chk("auto_done_color", color, 1);
        step();
        chk("auto_done_pulse", done, 0);
`else
        for (int i = 16; i <= 1000; i++) frame();
        chk("hold1000_busy", busy, 1);
        chk("hold1000_en", screen_en, 1);
        chk("hold1000_cursor", cursor_x, 320);
        chk("hold1000_done", done, 0);
`endif

        // Reset during SLIDE aborts with no done pulse
        rst = 1'b1;
        step();
        rst = 1'b0;
        win_valid = 1'b1;
        win_player = 1'b1;
        step();
        win_valid = 1'b0;
        for (int i = 0; i < 5; i++) frame();
        chk("midslide_cursor", cursor_x, 40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_en", screen_en, 0);
        chk("abort_color", color, 0);
        chk("abort_cursor", cursor_x, 0);
        chk("abort_done", done, 0);
        step();
        chk("abort_done_later", done, 0);

        // Restart coincident with a tick mid-BLINK
        win_valid = 1'b1;
        win_player = 1'b1;
        step();
        win_valid = 1'b0;
        for (int i = 0; i < 60; i++) frame();
        chk("rb_en_off", screen_en, 0);
        frame_tick = 1'b1;
        restart = 1'b1;
        step();
        frame_tick = 1'b0;
        restart = 1'b0;
        chk("rb_clear_en", screen_en, 0);
        chk("rb_clear_busy", busy, 1);
        chk("rb_clear_done", done, 0);
        step();
        step();
        chk("rb_wait_done", done, 0);
        chk("rb_wait_busy", busy, 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("rb_done", done, 1);
        chk("rb_done_busy", busy, 0);
        chk("rb_done_cursor", cursor_x, 0);
        chk("rb_done_color", color, 1);
        chk("rb_done_en", screen_en, 0);
        step();
        chk("rb_done_pulse", done, 0);

        // Restart in IDLE is ignored; win_valid wins when both are high
        restart = 1'b1;
        step();
        chk("idle_restart_busy", busy, 0);
        win_valid = 1'b1;
        win_player = 1'b0;
        step();
        win_valid = 1'b0;
        restart = 1'b0;
        chk("idle_both_busy", busy, 1);
        chk("idle_both_color", color, 0);
        chk("idle_both_en", screen_en, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/winner_seq_ctrl.md
Name: winner_seq_ctrl

Overview:
Sequences the Connect4 end-of-game winner screen on the VGA path. On a win it latches the winning player's colour, slides the winner text column from a start X to screen centre, blinks it, then holds it until restart (or timeout). Outputs drive the winner-screen renderer's enable, colour and cursorX inputs. Sits between the game-logic win detector and the pixel mux. All timing advances on the frame tick.

Parameters:
START_X, 10'd0, cursorX value loaded at slide start
CENTER_X, 10'd320, final cursorX; slide target
STEP, 8, cursorX increment per frame during slide (1..CENTER_X-START_X)
BLINK_FRAMES, 15, frames per blink half-period (>=1)
BLINKS, 3, number of full off/on blink cycles (>=1)
HOLD_FRAMES, 300, hold timeout in frames (used only with optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
win_valid  in  1  one-cycle pulse: winner decided
win_player  in  1  winning player (1 = red, 0 = cyan); sampled with win_valid
restart  in  1  level/pulse from debounced restart button
screen_en  out  1  enable for winner renderer
color  out  1  latched winner colour
cursorX  out  10  text column centre for renderer
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on return to IDLE after CLEAR

Behaviour:
- Single clock domain; all outputs registered. Reset (rst=1 at a clk edge): state=IDLE, screen_en=0, color=0, cursorX=START_X, busy=0, done=0, all counters 0. Reset mid-sequence aborts immediately; no done pulse.
- States: IDLE, SLIDE, BLINK, HOLD, CLEAR.
- IDLE: win_valid=1 at any cycle (not frame-gated) -> next cycle SLIDE, color=win_player, cursorX=START_X, screen_en=1, busy=1. restart ignored in IDLE; win_valid has priority if both high.
- SLIDE: on each frame_tick, if cursorX+STEP >= CENTER_X (11-bit compare, no wrap) -> cursorX=CENTER_X, go BLINK, frame_cnt=0, toggle_cnt=0; else cursorX+=STEP. Frames in SLIDE = ceil((CENTER_X-START_X)/STEP).
- BLINK: on each frame_tick frame_cnt++; when frame_cnt==BLINK_FRAMES-1 at a tick: screen_en toggles, frame_cnt=0, toggle_cnt++. First toggle turns screen off. After toggle 2*BLINKS (screen_en back to 1) -> HOLD, frame_cnt=0. Total BLINK duration = 2*BLINKS*BLINK_FRAMES frames.
- HOLD: screen_en=1, cursorX=CENTER_X. Exit only via restart (or timeout, see Optional Feature).
- restart=1 in SLIDE, BLINK or HOLD -> next cycle CLEAR, screen_en=0; restart has priority over a coincident frame_tick transition.
- CLEAR: screen_en=0; on the next frame_tick -> IDLE, done=1 for exactly that one cycle, busy=0, cursorX=START_X, color retained.
- win_valid outside IDLE ignored (no re-latch of color).
- frame_tick absent: state frozen (except restart/reset paths).

Optional Feature:
WINNER_AUTO_RESTART_EN. Defined: in HOLD, frame_cnt counts frame_ticks; when it reaches HOLD_FRAMES-1 at a tick -> CLEAR exactly as restart would. Not defined: HOLD waits indefinitely for restart; HOLD_FRAMES unused; frame counter idle in HOLD.

Test Plan:
- Reset then win_valid=1, win_player=1 -> next cycle busy=1, screen_en=1, color=1, cursorX=0; after 40 frame_ticks cursorX=320, state BLINK.
- Defaults, through BLINK -> screen_en=0 after tick 15, 1 after tick 30, ... 6 toggles, HOLD entered after 90 frame_ticks with screen_en=1.
- Non-dividing step: START_X=0, CENTER_X=320, STEP=7 -> cursorX 0,7,...,315 then saturates at 320 on tick 46, never exceeds 320.
- restart asserted coincident with frame_tick mid-BLINK -> CLEAR next cycle, screen_en=0; next frame_tick -> done=1 single cycle, busy=0.
- win_valid pulsed with win_player=0 during HOLD of a red win -> color stays 1; rst=1 during SLIDE -> next cycle all outputs reset values, no done pulse.
- With WINNER_AUTO_RESTART_EN, HOLD_FRAMES=300 -> CLEAR after 300 HOLD ticks, done one tick later; without macro, no exit after 1000 ticks.
